// File: rtl/sobel_frame_ctrl.sv
// Frame-level sequencer between the SPI pixel interface and the Sobel core.
// Forwards incoming gray pixels to the core, tracks the column/row of the next
// expected pixel, counts returned Sobel results and hands them to the SPI
// transmit path. After the last input pixel it waits in FLUSH until all
// results are back or the core has been idle for FLUSH_TIMEOUT cycles.
//
// Ports:
//   clk_i, nreset_i          clock, asynchronous active-low reset
//   start_i, abort_i         frame start (IDLE only), abort to IDLE
//   in_valid_i, in_px_i      pixel from SPI (one-cycle pulse)
//   sobel_px_o, sobel_valid_o pixel to Sobel core (one-cycle pulse)
//   sobel_rdy_i, sobel_px_i  result from Sobel core (one-cycle pulse)
//   out_px_o, out_valid_o    result to SPI transmit register
//   col_o, row_o             position of the next expected input pixel
//   busy_o                   frame in progress (RUN or FLUSH)
//   frame_done_o             one-cycle pulse on frame completion
//   overrun_o                sticky framing error
module sobel_frame_ctrl #(
  parameter int unsigned IMG_WIDTH     = 8,
  parameter int unsigned IMG_HEIGHT    = 8,
  parameter int unsigned PX_BITS       = 24,
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic                          clk_i,
  input  logic                          nreset_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic                          in_valid_i,
  input  logic [PX_BITS-1:0]            in_px_i,
  output logic [PX_BITS-1:0]            sobel_px_o,
  output logic                          sobel_valid_o,
  input  logic                          sobel_rdy_i,
  input  logic [PX_BITS-1:0]            sobel_px_i,
  output logic [PX_BITS-1:0]            out_px_o,
  output logic                          out_valid_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] row_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          overrun_o
);

  localparam int unsigned COL_W  = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W  = $clog2(IMG_HEIGHT);
  localparam int unsigned NPIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned CNT_W  = $clog2(NPIX + 1);
  localparam int unsigned TMO_W  = $clog2(FLUSH_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   out_cnt_q;
  logic [TMO_W-1:0]   tmo_q;

  logic start_acc, px_acc, last_px, px_bad, cnt_sat, cnt_en, rdy_bad;
  logic col_last, row_last, flush_done;

  // State register
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i)    state_d = RUN;
        RUN:     if (last_px)    state_d = FLUSH;
        FLUSH:   if (flush_done) state_d = DONE;
        DONE:                    state_d = IDLE;
        default:                 state_d = IDLE;
      endcase
    end
  end

  // Event decode feeding the registered outputs and counters
  always_comb begin
    start_acc  = 1'b0;
    px_acc     = 1'b0;
    px_bad     = 1'b0;
    col_last   = (col_o == COL_W'(IMG_WIDTH - 1));
    row_last   = (row_o == ROW_W'(IMG_HEIGHT - 1));
    cnt_sat    = (out_cnt_q == CNT_W'(NPIX));
    cnt_en     = 1'b0;
    rdy_bad    = 1'b0;
    flush_done = cnt_sat || (tmo_q == TMO_W'(FLUSH_TIMEOUT - 1));

    start_acc = (state_q == IDLE) && start_i && !abort_i;
    px_acc    = (state_q == RUN) && in_valid_i && !abort_i;
    // A pixel arriving outside RUN (including alongside start_i) is dropped
    px_bad    = in_valid_i && (state_q != RUN);
    cnt_en    = sobel_rdy_i && !cnt_sat && ((state_q == RUN) || (state_q == FLUSH));
    rdy_bad   = sobel_rdy_i && cnt_sat;
    last_px   = px_acc && col_last && row_last;
  end

  // Pixel forwarding, result path, position/count tracking and flags
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      sobel_px_o    <= '0;
      sobel_valid_o <= 1'b0;
      out_px_o      <= '0;
      out_valid_o   <= 1'b0;
      col_o         <= '0;
      row_o         <= '0;
      busy_o        <= 1'b0;
      frame_done_o  <= 1'b0;
      overrun_o     <= 1'b0;
      out_cnt_q     <= '0;
      tmo_q         <= '0;
    end else begin
      sobel_valid_o <= px_acc;
      if (px_acc) sobel_px_o <= in_px_i;

      // Results are forwarded regardless of state
      out_valid_o <= sobel_rdy_i;
      if (sobel_rdy_i) out_px_o <= sobel_px_i;

      busy_o       <= (state_d == RUN) || (state_d == FLUSH);
      frame_done_o <= (state_d == DONE);

      if (abort_i || start_acc) begin
        col_o <= '0;
        row_o <= '0;
      end else if (px_acc) begin
        if (col_last) begin
          col_o <= '0;
          row_o <= row_last ? '0 : row_o + ROW_W'(1);
        end else begin
          col_o <= col_o + COL_W'(1);
        end
      end

      if (start_acc)   out_cnt_q <= '0;
      else if (cnt_en) out_cnt_q <= out_cnt_q + CNT_W'(1);

      // Idle timer only runs in FLUSH; any result restarts it
      if (start_acc)               tmo_q <= '0;
      else if (state_q == FLUSH)   tmo_q <= sobel_rdy_i ? '0 : tmo_q + TMO_W'(1);

      // Sticky error; an accepted start clears it and wins over a same-cycle set
      if (!abort_i) begin
        if (start_acc)              overrun_o <= 1'b0;
        else if (px_bad || rdy_bad) overrun_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed self-checking bench for sobel_frame_ctrl with a 4x3 frame and an
// 8-cycle flush timeout.
module tb_sobel_frame_ctrl;

  localparam int unsigned W   = 4;
  localparam int unsigned H   = 3;
  localparam int unsigned PXB = 24;
  localparam int unsigned FT  = 8;

  logic            clk_i       = 1'b0;
  logic            nreset_i    = 1'b1;
  logic            start_i     = 1'b0;
  logic            abort_i     = 1'b0;
  logic            in_valid_i  = 1'b0;
  logic [PXB-1:0]  in_px_i     = '0;
  logic            sobel_rdy_i = 1'b0;
  logic [PXB-1:0]  sobel_px_i  = '0;
  logic [PXB-1:0]  sobel_px_o;
  logic            sobel_valid_o;
  logic [PXB-1:0]  out_px_o;
  logic            out_valid_o;
  logic [1:0]      col_o;
  logic [1:0]      row_o;
  logic            busy_o;
  logic            frame_done_o;
  logic            overrun_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  sobel_frame_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PX_BITS(PXB), .FLUSH_TIMEOUT(FT)
  ) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .start_i(start_i), .abort_i(abort_i),
    .in_valid_i(in_valid_i), .in_px_i(in_px_i),
    .sobel_px_o(sobel_px_o), .sobel_valid_o(sobel_valid_o),
    .sobel_rdy_i(sobel_rdy_i), .sobel_px_i(sobel_px_i),
    .out_px_o(out_px_o), .out_valid_o(out_valid_o),
    .col_o(col_o), .row_o(row_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .overrun_o(overrun_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // 12 pixels spaced 3 cycles; the first n_res of pixels 1..11 get a result
  task automatic send_frame(input int n_res);
    for (int i = 0; i < 12; i++) begin
      in_valid_i = 1'b1;
      in_px_i    = PXB'(i + 1);
      tick();
      in_valid_i = 1'b0;
      chk("sv_pulse", sobel_valid_o, 1);
      chk("sv_px", sobel_px_o, i + 1);
      chk("col", col_o, (i + 1) % 4);
      chk("row", row_o, ((i + 1) / 4) % 3);
      chk("busy_run", busy_o, 1);
      if (i < 11) begin
        sobel_rdy_i = (i < n_res);
        sobel_px_i  = PXB'(32'hA00000 + i + 1);
        tick();
        sobel_rdy_i = 1'b0;
        chk("sv_one_cycle", sobel_valid_o, 0);
        chk("ov_pulse", out_valid_o, (i < n_res));
        if (i < n_res) chk("out_px", out_px_o, 32'hA00000 + i + 1);
        tick();
        chk("ov_one_cycle", out_valid_o, 0);
        chk("no_done_mid", frame_done_o, 0);
      end
    end
  endtask

  // Final (12th) result in FLUSH, then the done pulse
  task automatic finish_full();
    sobel_rdy_i = 1'b1;
    sobel_px_i  = 24'hA0000C;
    tick();
    sobel_rdy_i = 1'b0;
    chk("last_ov", out_valid_o, 1);
    chk("last_out_px", out_px_o, 32'hA0000C);
    chk("flush_busy", busy_o, 1);
    chk("flush_no_done", frame_done_o, 0);
    tick();
    chk("done_pulse", frame_done_o, 1);
    chk("done_busy_low", busy_o, 0);
    tick();
    chk("done_one_cycle", frame_done_o, 0);
    chk("idle_busy", busy_o, 0);
  endtask

  initial begin
    // Reset
    #2 nreset_i = 1'b0;
    #10;
    chk("rst_sv", sobel_valid_o, 0);
    chk("rst_sv_px", sobel_px_o, 0);
    chk("rst_out_px", out_px_o, 0);
    chk("rst_col", col_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", frame_done_o, 0);
    chk("rst_overrun", overrun_o, 0);
    nreset_i = 1'b1;
    tick();

    // Pixel in IDLE is dropped and flags overrun, which sticks
    in_valid_i = 1'b1;
    in_px_i    = 24'h000055;
    tick();
    in_valid_i = 1'b0;
    chk("idle_px_drop", sobel_valid_o, 0);
    chk("idle_overrun", overrun_o, 1);
    tick();
    chk("overrun_sticky", overrun_o, 1);

    // start with a pixel in the same cycle: pixel dropped, overrun cleared
    start_i    = 1'b1;
    in_valid_i = 1'b1;
    tick();
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    chk("start_px_drop", sobel_valid_o, 0);
    chk("start_clears_ovr", overrun_o, 0);
    chk("start_busy", busy_o, 1);
    chk("start_col", col_o, 0);

    // Full frame with all 12 results
    send_frame(12);
    finish_full();

    // Result while the count is saturated: forwarded, flags overrun
    sobel_rdy_i = 1'b1;
    sobel_px_i  = 24'h123456;
    tick();
    sobel_rdy_i = 1'b0;
    chk("sat_ov", out_valid_o, 1);
    chk("sat_out_px", out_px_o, 32'h123456);
    chk("sat_overrun", overrun_o, 1);
    tick();

    // Timeout frame: 8 results, then one in FLUSH restarting the idle timer
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("restart_clears_ovr", overrun_o, 0);
    send_frame(8);
    for (int k = 1; k <= 13; k++) begin
      sobel_rdy_i = (k == 4);
      sobel_px_i  = 24'hB00000;
      in_valid_i  = (k == 2);
      tick();
      sobel_rdy_i = 1'b0;
      in_valid_i  = 1'b0;
      chk("tmo_done", frame_done_o, (k == 12));
      chk("tmo_busy", busy_o, (k < 12));
      chk("flush_overrun", overrun_o, (k >= 2));
      if (k == 2) chk("flush_px_drop", sobel_valid_o, 0);
      if (k == 4) chk("flush_ov", out_valid_o, 1);
    end

    // Abort after 5 pixels
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("abort_pre_ovr", overrun_o, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1;
      in_px_i    = PXB'(i + 1);
      tick();
      in_valid_i = 1'b0;
      tick();
    end
    chk("pre_abort_col", col_o, 1);
    chk("pre_abort_row", row_o, 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_col", col_o, 0);
    chk("abort_row", row_o, 0);
    chk("abort_ovr_kept", overrun_o, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_done", frame_done_o, 0);
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    send_frame(12);
    finish_full();

    // Asynchronous reset mid-RUN
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1;
      in_px_i    = PXB'(i + 1);
      tick();
      in_valid_i = 1'b0;
      tick();
    end
    #3 nreset_i = 1'b0;
    #1;
    chk("arst_sv_px", sobel_px_o, 0);
    chk("arst_out_px", out_px_o, 0);
    chk("arst_col", col_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_done", frame_done_o, 0);
    tick();
    nreset_i = 1'b1;
    tick();
    in_valid_i = 1'b1;
    in_px_i    = 24'h000077;
    tick();
    in_valid_i = 1'b0;
    chk("post_rst_px_drop", sobel_valid_o, 0);
    chk("post_rst_no_done", frame_done_o, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("post_rst_busy", busy_o, 1);
    in_valid_i = 1'b1;
    in_px_i    = 24'h000099;
    tick();
    in_valid_i = 1'b0;
    chk("post_rst_sv", sobel_valid_o, 1);
    chk("post_rst_sv_px", sobel_px_o, 32'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
